rom_arbiter: RTL
================

# rom_arbiter

Shares the single asynchronous-read instruction ROM between two requesters: the CPU instruction-fetch port (port F) and a debug/readback port (port D) used by the loader and bench monitors. Port F has fixed priority, and a bounded-wait guard keeps port D from being starved. Read data is registered and returned one cycle after grant with a per-port valid strobe. The block sits between the CPU fetch stage, the debug controller and `rom`.

## Interface
- `ADDR_W`, 15, ROM word-address width
- `DATA_W`, 16, instruction width
- `MAX_WAIT`, 4, consecutive denied port-D cycles before port D is forced a grant; legal range 1..15
- `clk_i`  in  1  single system clock, rising edge
- `rst_n_i`  in  1  reset, asynchronous assert, active-low
- `f_req_i`  in  1  fetch read request
- `f_addr_i`  in  ADDR_W  fetch word address
- `f_gnt_o`  out  1  fetch granted this cycle
- `f_rvalid_o`  out  1  fetch read data valid
- `f_rdata_o`  out  DATA_W  fetch read data
- `d_req_i`, `d_addr_i`, `d_gnt_o`, `d_rvalid_o`, `d_rdata_o`: same directions, widths and meanings as the port-F signals, for the debug port
- `rom_addr_o`  out  ADDR_W  address to `rom.addr_i`
- `rom_data_i`  in  DATA_W  data from `rom.data_o` (combinational)

## Operation
- Grant owner per cycle is one of OWN_NONE, OWN_F or OWN_D. It is computed combinationally from the requests and `wait_cnt`:
  - `wait_cnt == MAX_WAIT` and `d_req_i` -> OWN_D
  - else `f_req_i` -> OWN_F
  - else `d_req_i` -> OWN_D
  - else OWN_NONE
- Exactly one of the two grant outputs can be high. Both are low while `rst_n_i` is low.
- `rom_addr_o` is the granted port's address, or 0 when the owner is OWN_NONE.
- On the clock edge, `rom_data_i` is captured into the granted port's `rdata` register, and that port's `rvalid` is set for exactly one cycle. The other port's `rdata` holds its value and its `rvalid` clears.
- `wait_cnt`:
  - increments (saturating at MAX_WAIT) on each cycle with `d_req_i`=1 and `d_gnt_o`=0
  - clears on a port-D grant or when `d_req_i`=0
- Requesters must hold `addr` stable while `req` is high and ungranted. A request may be withdrawn before grant with no side effect.
- Each grant serves one read. A port holding `req` high is serviced again in the next cycle, giving back-to-back reads.
- Simultaneous `f_req_i` and `d_req_i` below the starvation limit: F wins and D's `wait_cnt` increments.
- When both ports request the same address, the two grants are still serialized.

## Timing
- Grant: combinational, in the same cycle as `req`.
- Read latency is 1 cycle: the grant happens in cycle N and `rvalid` and `rdata` appear in cycle N+1.
- Throughput is one read per cycle in total across both ports.
- Worst-case port-D wait is MAX_WAIT cycles from `d_req_i` rising to `d_gnt_o`.
- Reset values: `f_gnt_o`/`d_gnt_o` 0, `f_rvalid_o`/`d_rvalid_o` 0, `f_rdata_o`/`d_rdata_o` 0, `rom_addr_o` 0, `wait_cnt` 0.
- Reset asserted mid-read: the pending `rvalid` is lost and is never emitted after release. The first grant after release follows the normal priority rules, with `wait_cnt`=0.

## Structure
- Shared package `rom_arb_pkg`:
  - `ADDR_W`, `DATA_W`
  - owner enum `own_e` {OWN_NONE, OWN_F, OWN_D}
- Natural sub-module: `starve_counter`, a saturating up-counter with inputs `inc_i`/`clr_i` and output `at_max_o`, parameterized by MAX_WAIT.
- Remaining logic in the top-level: the owner decode, the address mux and the per-port response registers.

## Test plan
The bench ROM model is preloaded with `rom[a] = a ^ 16'hA5A5`; MAX_WAIT=4.
- **Reset:** hold `rst_n_i`=0 with both `req` inputs high.
  - Required: both grants 0, both `rvalid` 0, `rom_addr_o`=0.
  - After release the first grant goes to F.
- **Single F read:** `f_req_i`=1 with `f_addr_i`=3 for one cycle.
  - Required: `f_gnt_o`=1 and `rom_addr_o`=3 in that cycle.
  - Next cycle: `f_rvalid_o`=1 and `f_rdata_o`=16'hA5A6.
- **Back-to-back F:** addresses 0, 1, 2 on consecutive cycles.
  - Required: `f_rvalid_o` high for 3 consecutive cycles with data A5A5, A5A4, A5A7.
- **Starvation guard:** F requests continuously on address 0; D requests address 5 from cycle 0.
  - Required: F granted in cycles 0–3 and D granted in cycle 4.
  - `d_rdata_o`=16'hA5A0 in cycle 5; F granted again in cycle 5.
- **Idle D:** `d_req_i` alone with address 7.
  - Required: immediate grant; `d_rvalid_o` next cycle with 16'hA5A2.
  - `f_rdata_o` unchanged.
- **Reset mid-read:** grant F at address 1, then assert `rst_n_i` before the next edge.
  - Required: `f_rvalid_o` never rises.
  - `f_rdata_o`=0 after release.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared widths and grant-owner encoding for the instruction-ROM arbiter.
package rom_arb_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_F,
        OWN_D
    } own_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive denied debug-port cycles; at_max_o forces a debug grant.
module starve_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

    logic [3:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (inc_i && cnt != LIMIT) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign at_max_o = (cnt == LIMIT);

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter for the asynchronous instruction ROM: fetch has priority,
// debug gets a forced grant after MAX_WAIT denied cycles; read data is registered per port.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              f_req_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    output logic              f_gnt_o,
    output logic              f_rvalid_o,
    output logic [DATA_W-1:0] f_rdata_o,
    input  logic              d_req_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i
);

    own_e owner;
    logic at_max;

    // NOTE: the default assignment first keeps this combinational block from inferring a latch.
    always_comb begin
        owner = OWN_NONE;
        if (!rst_n_i) begin
            owner = OWN_NONE;
        end else if (at_max && d_req_i) begin
            owner = OWN_D;
        end else if (f_req_i) begin
            owner = OWN_F;
        end else if (d_req_i) begin
            owner = OWN_D;
        end
    end

    assign f_gnt_o = (owner == OWN_F);
    assign d_gnt_o = (owner == OWN_D);

    always_comb begin
        rom_addr_o = '0;
        case (owner)
            OWN_F:   rom_addr_o = f_addr_i;
            OWN_D:   rom_addr_o = d_addr_i;
            default: rom_addr_o = '0;
        endcase
    end

    starve_counter #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (d_req_i && !d_gnt_o),
        .clr_i   (!d_req_i || d_gnt_o),
        .at_max_o(at_max)
    );

    // Async reset drops any read granted in the last cycle, so its rvalid is never emitted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            f_rvalid_o <= 1'b0;
            f_rdata_o  <= '0;
            d_rvalid_o <= 1'b0;
            d_rdata_o  <= '0;
        end else begin
            f_rvalid_o <= f_gnt_o;
            d_rvalid_o <= d_gnt_o;
            if (f_gnt_o) f_rdata_o <= rom_data_i;
            if (d_gnt_o) d_rdata_o <= rom_data_i;
        end
    end

endmodule
